// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential FP multiplier.
// Holds field widths, special encodings, FSM states and an operand unpacker.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_t;

  // Operand facts the NORM stage needs once the mantissa is in the core.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } op_t;

  // Denormals (exp == 0) are flushed: hidden bit and fraction both zero.
  function automatic fp_t unpack(input logic [31:0] x);
    fp_t r;
    logic exp_max;
    logic frac_nz;
    exp_max   = &x[30:23];
    frac_nz   = |x[22:0];
    r.sign    = x[31];
    r.exp     = x[30:23];
    r.is_zero = ~|x[30:23];
    r.is_inf  = exp_max & ~frac_nz;
    r.is_nan  = exp_max & frac_nz;
    r.mant    = r.is_zero ? '0 : {1'b1, x[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// 24x24 shift-add mantissa multiplier, one partial product per step.
// Ports: clk, rst, load (capture a/b), step (one iteration), prod, last.
module mant_mul_seq
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MANT_W:0]   a,
  input  logic [MANT_W:0]   b,
  input  logic              step,
  output logic [2*MANT_W+1:0] prod,
  output logic              last
);

  localparam int PW = 2 * (MANT_W + 1);

  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [MANT_W:0] mplier;
  logic [4:0]      cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{(MANT_W+1){1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end
  end

  assign prod = acc;
  // High during the step that performs the final (24th) iteration.
  assign last = (cnt == 5'(MANT_W));

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle IEEE-754 single multiplier with start/busy/done handshake.
// Ports: clk, rst, start, src1, src2 in; busy, done, mulOut out.
module fp_multiplier_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] mulOut
);

  state_t state;
  op_t    oa;
  op_t    ob;
  fp_t    ua;
  fp_t    ub;

  logic [47:0] prod;
  logic        last;
  logic        load;
  logic        step;

  logic               sign;
  logic signed [9:0]  e_raw;
  logic signed [9:0]  e_n;
  logic [22:0]        frac;
  logic [31:0]        res;

  assign ua   = unpack(src1);
  assign ub   = unpack(src2);
  assign load = (state == IDLE) && start;
  assign step = (state == MUL);

  mant_mul_seq u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .a    (ua.mant),
    .b    (ub.mant),
    .step (step),
    .prod (prod),
    .last (last)
  );

  assign sign  = oa.sign ^ ob.sign;
  assign e_raw = signed'({2'b00, oa.exp})
               + signed'({2'b00, ob.exp})
               - 10'sd127;

  // Product of two [1,2) values lies in [1,4); bit 47 means [2,4).
  always_comb begin
    e_n  = e_raw;
    frac = prod[45:23];
    if (prod[47]) begin
      e_n  = e_raw + 10'sd1;
      frac = prod[46:24];
    end
  end

  always_comb begin
    res = {sign, e_n[7:0], frac};
    if (oa.is_nan || ob.is_nan)
      res = QNAN;
    else if ((oa.is_inf && ob.is_zero) ||
             (ob.is_inf && oa.is_zero))
      res = QNAN;
    else if (oa.is_inf || ob.is_inf)
      res = {sign, POS_INF[30:0]};
    else if (oa.is_zero || ob.is_zero)
      res = {sign, 31'd0};
    else if (e_n >= 10'sd255)
      res = {sign, POS_INF[30:0]};
    else if (e_n <= 10'sd0)
      res = {sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mulOut <= '0;
      oa     <= '0;
      ob     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            oa    <= '{ua.sign, ua.exp, ua.is_zero,
                       ua.is_inf, ua.is_nan};
            ob    <= '{ub.sign, ub.exp, ub.is_zero,
                       ub.is_inf, ub.is_nan};
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          if (last)
            state <= NORM;
        end
        NORM: begin
          mulOut <= res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
